// File: rtl/hilo_muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that produces a one-cycle {Hi,Lo} write.
// Optional build macro: MULDIV_EARLY_OUT_EN (multiply skips trailing zero multiplier bits).
module hilo_muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [1:0]           i_op,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic                 i_hilo_read_req,
    input  logic                 i_flush,
    output logic                 o_busy,
    output logic                 o_stall,
    output logic                 o_hilo_en,
    output logic [2*WIDTH-1:0]   o_hilo_write,
    output logic                 o_div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_is_div, r_sa, r_sb, r_dbz;
    logic [WIDTH-1:0]     r_opa, r_opb;
    logic [2*WIDTH-1:0]   r_prod, r_hold;
    logic [CW-1:0]        r_cnt;

    logic                 w_is_div, w_signed, w_sa, w_sb, w_accept, w_dbz_in;
    logic [WIDTH-1:0]     w_abs_a, w_abs_b;
    logic [WIDTH:0]       w_mul_sum, w_div_shift, w_div_diff;
    logic [2*WIDTH-1:0]   w_mul_next, w_div_next, w_fixed;
    logic [WIDTH-1:0]     w_quot, w_rem;
    logic                 w_div_ok, w_run_done, w_early;

    // Operand decode: signed ops iterate on magnitudes and fix signs at the end
    assign w_is_div = i_op[1];
    assign w_signed = ~i_op[0];
    assign w_sa     = w_signed & i_a[WIDTH-1];
    assign w_sb     = w_signed & i_b[WIDTH-1];
    assign w_abs_a  = w_sa ? -i_a : i_a;
    assign w_abs_b  = w_sb ? -i_b : i_b;
    assign w_accept = i_start & ~i_flush;
    assign w_dbz_in = w_is_div & (i_b == '0);

    // Shift-add step: multiplicand into the upper half, then shift right
    assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_opb[0] ? {1'b0, r_opa} : '0);
    assign w_mul_next = {w_mul_sum, r_prod[WIDTH-1:1]};

    // Restoring divide step: rem in the upper half, dividend/quotient in the lower
    assign w_div_shift = r_prod[2*WIDTH-1:WIDTH-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_ok    = ~w_div_diff[WIDTH];
    assign w_div_next  = {(w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                          r_prod[WIDTH-2:0], w_div_ok};

`ifdef MULDIV_EARLY_OUT_EN
    logic [2*WIDTH-1:0] w_mul_skip;
    assign w_early    = ~r_is_div & (r_opb[WIDTH-1:1] == '0);
    assign w_mul_skip = w_mul_next >> r_cnt;
`else
    assign w_early    = 1'b0;
`endif

    assign w_run_done = (r_cnt == '0) | w_early;

    assign w_quot = r_prod[WIDTH-1:0];
    assign w_rem  = r_prod[2*WIDTH-1:WIDTH];

    always_comb begin
        w_fixed = r_prod;
        if (!r_dbz) begin
            if (!r_is_div)
                w_fixed = (r_sa ^ r_sb) ? -r_prod : r_prod;
            else
                w_fixed = {(r_sa ? -w_rem : w_rem), ((r_sa ^ r_sb) ? -w_quot : w_quot)};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = w_dbz_in ? S_FINISH : S_RUN;
            S_RUN:    if (i_flush) w_state_nxt = S_IDLE;
                      else if (w_run_done) w_state_nxt = S_FINISH;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_is_div <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_dbz    <= 1'b0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_prod   <= '0;
            r_hold   <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_is_div <= w_is_div;
                    r_dbz    <= w_dbz_in;
                    r_cnt    <= CW'(WIDTH-1);
                    r_opa    <= w_abs_a;
                    r_opb    <= w_abs_b;
                    if (w_dbz_in) begin
                        r_sa   <= 1'b0;
                        r_sb   <= 1'b0;
                        r_prod <= {i_a, {WIDTH{1'b1}}};
                    end else begin
                        r_sa   <= w_sa;
                        r_sb   <= w_sb;
                        r_prod <= w_is_div ? {{WIDTH{1'b0}}, w_abs_a} : '0;
                    end
                end
                S_RUN: if (!i_flush) begin
                    if (r_is_div) begin
                        r_prod <= w_div_next;
                    end else begin
`ifdef MULDIV_EARLY_OUT_EN
                        // Remaining multiplier bits are zero: finish all shifts at once
                        r_prod <= w_early ? w_mul_skip : w_mul_next;
`else
                        r_prod <= w_mul_next;
`endif
                        r_opb  <= r_opb >> 1;
                    end
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                S_FINISH: if (!i_flush) r_hold <= w_fixed;
                default: ;
            endcase
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_stall       = o_busy & (i_start | i_hilo_read_req);
    assign o_hilo_en     = (r_state == S_FINISH) & ~i_flush;
    assign o_div_by_zero = o_hilo_en & r_dbz;
    assign o_hilo_write  = (r_state == S_FINISH) ? w_fixed : r_hold;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Bench for hilo_muldiv_sequencer: directed vector table, multi-cycle sequences, random ops vs model.
module tb_hilo_muldiv_sequencer;

    localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [1:0]    i_op = '0;
    logic [W-1:0]  i_a = '0, i_b = '0;
    logic          i_hilo_read_req = 1'b0;
    logic          i_flush = 1'b0;
    logic          o_busy, o_stall, o_hilo_en, o_div_by_zero;
    logic [2*W-1:0] o_hilo_write;

    int total = 0;
    int bad   = 0;

    hilo_muldiv_sequencer #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_op(i_op), .i_a(i_a), .i_b(i_b),
        .i_hilo_read_req(i_hilo_read_req), .i_flush(i_flush),
        .o_busy(o_busy), .o_stall(o_stall), .o_hilo_en(o_hilo_en),
        .o_hilo_write(o_hilo_write), .o_div_by_zero(o_div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero like MIPS
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        model = '0;
        case (op)
            2'd0: model = sa * sb;
            2'd1: model = ua * ub;
            2'd2: if (b == 0) model = {a, 32'hFFFF_FFFF};
                  else begin q = sa / sb; r = sa % sb; model = {r[31:0], q[31:0]}; end
            default: if (b == 0) model = {a, 32'hFFFF_FFFF};
                  else begin uq = ua / ub; ur = ua % ub; model = {ur[31:0], uq[31:0]}; end
        endcase
    endfunction

    // Issues one op; lat = cycles from accepting edge to the HiLoEn cycle (-1 on timeout)
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int lat, output logic dbz);
        @(negedge clk);
        i_start = 1'b1; i_op = op; i_a = a; i_b = b;
        lat = -1; res = '0; dbz = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_hilo_en) begin
                lat = k; res = o_hilo_write; dbz = o_div_by_zero;
                break;
            end
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [63:0] exp_hilo;
        logic        exp_dbz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [63:0] res;
        int lat, pulses, exp_lat;
        logic dbz;
        logic [1:0] op;
        logic [31:0] a, b;

        vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 33};
        vecs[1] = '{2'd0, 32'hFFFF_FFF9, 32'd3,         64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 33};
        vecs[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 33};
        vecs[3] = '{2'd3, 32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF, 1'b1, 1};
        vecs[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 33};
        vecs[5] = '{2'd2, 32'd7,         32'd0,         64'h0000_0007_FFFF_FFFF, 1'b1, 1};
        vecs[6] = '{2'd3, 32'd50,        32'd7,         64'h0000_0001_0000_0007, 1'b0, 33};
        vecs[7] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 33};
        vecs[8] = '{2'd2, 32'd100,       32'hFFFF_FFF9, 64'h0000_0002_FFFF_FFF2, 1'b0, 33};
        vecs[9] = '{2'd1, 32'd0,         32'h1234_5678, 64'h0,                   1'b0, 33};

        // Reset state
        #1;
        chk("rst_busy", {63'b0, o_busy}, 64'd0);
        chk("rst_stall", {63'b0, o_stall}, 64'd0);
        chk("rst_hilo_en", {63'b0, o_hilo_en}, 64'd0);
        chk("rst_hilo_write", o_hilo_write, 64'd0);
        chk("rst_dbz", {63'b0, o_div_by_zero}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Directed vector table
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, dbz);
            chk($sformatf("vec%0d_hilo", i), res, vecs[i].exp_hilo);
            chk($sformatf("vec%0d_dbz", i), {63'b0, dbz}, {63'b0, vecs[i].exp_dbz});
            if (vecs[i].op[1] || !EARLY)
                chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
            @(negedge clk);
            chk($sformatf("vec%0d_busy_after", i), {63'b0, o_busy}, 64'd0);
            chk($sformatf("vec%0d_hold", i), o_hilo_write, vecs[i].exp_hilo);
        end

        // Early-out multiply latency (full length when the feature is off)
        run_op(2'd1, 32'd5, 32'd1, res, lat, dbz);
        chk("early_lat", 64'(lat), EARLY ? 64'd2 : 64'd33);
        chk("early_res", res, 64'd5);

        // Stall: MFHI from N+5, second Start from N+3 accepted at N+34
        @(negedge clk);
        i_start = 1'b1; i_op = 2'd1; i_a = 32'hFFFF_FFFF; i_b = 32'hFFFF_FFFF;
        pulses = 0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            i_start = (k >= 3 && k <= 34);
            i_op = 2'd3; i_a = 32'd1000; i_b = 32'd3;
            i_hilo_read_req = (k >= 5 && k <= 34);
            #1;
            chk($sformatf("stall_k%0d", k), {63'b0, o_stall}, {63'b0, (k >= 3 && k <= 33)});
            if (o_hilo_en) pulses++;
            if (k == 33) chk("stall_en1", {63'b0, o_hilo_en}, 64'd1);
            if (k == 33) chk("stall_res1", o_hilo_write, model(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
            if (k == 67) chk("stall_en2", {63'b0, o_hilo_en}, 64'd1);
            if (k == 67) chk("stall_res2", o_hilo_write, model(2'd3, 32'd1000, 32'd3));
        end
        chk("stall_pulses", 64'(pulses), 64'd2);
        i_start = 1'b0; i_hilo_read_req = 1'b0;

        // Flush during DIVU 50/7 at N+10
        @(negedge clk);
        i_start = 1'b1; i_op = 2'd3; i_a = 32'd50; i_b = 32'd7;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            i_flush = (k == 10);
            #1;
            if (o_hilo_en) pulses++;
            if (k == 9)  chk("flush_busy_before", {63'b0, o_busy}, 64'd1);
            if (k == 11) chk("flush_busy_after", {63'b0, o_busy}, 64'd0);
        end
        chk("flush_no_en", 64'(pulses), 64'd0);
        chk("flush_hold", o_hilo_write, model(2'd3, 32'd1000, 32'd3));

        // Flush beats Start in IDLE
        @(negedge clk);
        i_start = 1'b1; i_flush = 1'b1; i_op = 2'd3; i_a = 32'd9; i_b = 32'd0;
        @(negedge clk);
        i_start = 1'b0; i_flush = 1'b0;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            if (o_busy || o_hilo_en) pulses++;
            @(negedge clk);
        end
        chk("flush_idle_ignored", 64'(pulses), 64'd0);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        i_start = 1'b1; i_op = 2'd0; i_a = 32'd123; i_b = 32'd456;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        i_hilo_read_req = 1'b1;
        #1;
        chk("pre_rst_stall", {63'b0, o_stall}, 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", {63'b0, o_busy}, 64'd0);
        chk("arst_stall", {63'b0, o_stall}, 64'd0);
        chk("arst_hilo_write", o_hilo_write, 64'd0);
        chk("arst_hilo_en", {63'b0, o_hilo_en}, 64'd0);
        @(negedge clk);
        rst = 1'b0; i_hilo_read_req = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_hilo_en) pulses++;
        end
        chk("arst_no_en", 64'(pulses), 64'd0);

        // Randomized ops against the model
        for (int n = 0; n < 200; n++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(op, a, b, res, lat, dbz);
            chk($sformatf("rnd%0d_op%0d_res", n, op), res, model(op, a, b));
            chk($sformatf("rnd%0d_dbz", n), {63'b0, dbz}, {63'b0, (op[1] && b == 0)});
            exp_lat = (op[1] && b == 0) ? 1 : 33;
            if (op[1] || !EARLY)
                chk($sformatf("rnd%0d_lat", n), 64'(lat), 64'(exp_lat));
            else if (lat < 2 || lat > 33)
                chk($sformatf("rnd%0d_lat_range", n), 64'(lat), 64'd33);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_sequencer.md
Name: hilo_muldiv_sequencer

Overview:
- Multi-cycle multiply/divide controller that owns the sequencing of writes into the EX-stage HiLo register.
- Accepts MULT/MULTU/DIV/DIVU operands from EX and iterates one bit per cycle.
- Delivers the 64-bit {Hi,Lo} result as a one-cycle HiLo write.
- Stalls the front of the pipeline while busy whenever the pipeline issues a new mul/div or reads HiLo (MFHI/MFLO).

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH; iteration count = WIDTH.

Ports:
- Clock  in  1  pipeline clock
- Reset  in  1  asynchronous, active-high; clears all state
- Start  in  1  EX holds a mul/div op this cycle
- Op  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
- A  in  WIDTH  rs operand (multiplicand / dividend)
- B  in  WIDTH  rt operand (multiplier / divisor)
- HiLoReadReq  in  1  EX holds MFHI/MFLO this cycle
- Flush  in  1  abort in-flight op (branch/exception squash)
- Busy  out  1  op in flight
- Stall  out  1  freeze IF/ID/EX this cycle
- HiLoEn  out  1  one-cycle HiLo write enable
- HiLoWrite  out  2*WIDTH  {Hi,Lo} write data
- DivByZero  out  1  one-cycle flag, coincident with HiLoEn

Behaviour:
- Reset values: Busy=0, Stall=0, HiLoEn=0, HiLoWrite=0, DivByZero=0, state=IDLE, counter=0.
- States:
  - IDLE:
    - Start & !Flush: latch Op, record operand signs, latch |A| and |B| (raw values for unsigned ops); go to RUN; counter=WIDTH-1.
    - DIV/DIVU with B==0: go directly to FINISH with the div-by-zero result.
  - RUN:
    - Multiply: shift-add; if multiplier LSB=1, add multiplicand into the upper half of the product, then shift right by 1.
    - Divide: restoring; shift {rem,quot} left by 1, trial-subtract the divisor, set the quotient bit if the result is non-negative.
    - Exits to FINISH when counter==0; decrements otherwise.
  - FINISH:
    - Apply sign fix-up.
      - MULT: negate the 64-bit product if the operand signs differ.
      - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
    - Drive HiLoWrite and assert HiLoEn for exactly this cycle.
      - Mul: Hi=product[63:32], Lo=product[31:0].
      - Div: Hi=remainder, Lo=quotient.
    - Return to IDLE.
- Latency: Start accepted on edge N; HiLoEn high during cycle N+WIDTH+1 (33 cycles for WIDTH=32). Div-by-zero: HiLoEn in cycle N+1.
- Busy=1 in RUN and FINISH. Busy is 0 in IDLE, including the cycle in which Start is accepted.
- Stall (combinational) = Busy & (Start | HiLoReadReq).
  - An MFHI/MFLO stalls through the FINISH cycle and proceeds the cycle after HiLoEn, so it reads the new value.
  - Start while Busy is held by Stall and is not accepted. It is accepted in the IDLE cycle after FINISH; no back-to-back overlap.
- Flush:
  - In RUN/FINISH: return to IDLE next edge; HiLoEn suppressed; HiLo keeps its old value.
  - In IDLE: wins over a simultaneous Start (Start ignored).
- Div-by-zero result: Hi=A, Lo=all ones, DivByZero=1 with HiLoEn.
- DIV of most-negative / -1: Lo=0x80000000, Hi=0, using 2's-complement wrap; no flag.
- HiLoWrite holds its last value outside FINISH; only HiLoEn qualifies it.
- Async Reset mid-operation: immediate return to IDLE; no HiLoEn is ever emitted for the aborted op.

Optional Feature:
- MULDIV_EARLY_OUT_EN: when defined, a RUN-state multiply whose remaining unshifted multiplier bits are all zero skips the remaining iterations.
  - The partial product is shifted right by the remaining count in one step, then the block goes to FINISH.
  - Results are unchanged; latency becomes data-dependent, minimum 2 cycles (Start edge to HiLoEn).
  - Division is unaffected.
- When not defined, every multiply takes the full WIDTH iterations.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HiLoEn at N+33, HiLoWrite=0xFFFFFFFE_00000001, Busy low the next cycle.
- MULT A=-7 (0xFFFFFFF9), B=3 -> HiLoWrite=0xFFFFFFFF_FFFFFFEB. DIV A=-7, B=2 -> Hi=0xFFFFFFFF (-1), Lo=0xFFFFFFFD (-3).
- DIVU A=100, B=0 -> HiLoEn and DivByZero at N+1, Hi=100, Lo=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0, DivByZero=0.
- HiLoReadReq held from N+5 -> Stall=1 from N+5 through N+33, Stall=0 at N+34. A second Start at N+3 -> stalled and accepted at N+34, second HiLoEn at N+67.
- Flush at N+10 during DIVU 50/7 -> Busy=0 at N+11, no HiLoEn pulse through N+40. Flush with Start in IDLE -> Busy stays 0.
- Reset asserted asynchronously mid-RUN (between edges) -> all outputs 0 immediately. With MULDIV_EARLY_OUT_EN, MULTU 5x1 -> HiLoEn at N+2, Lo=5.
